ca_row_engine: RTL and testbench

//  Elementary (1-D, 3-cell) cellular-automaton generator feeding the dual-port debug RAM.

---
 rtl/ca_row_engine_pkg.sv | 17 +
 rtl/ca_row_engine_rule_row.sv | 24 ++
 rtl/ca_row_engine.sv | 131 +++++++++++++
 tb/tb_ca_row_engine.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/ca_row_engine_pkg.sv
// Shared types for the cellular-automaton row engine: FSM encoding and seed constant.
package ca_row_engine_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CLEAR = 2'd1,
    S_LOAD  = 2'd2,
    S_STORE = 2'd3
  } ca_state_e;

  localparam logic [7:0] SEED_BYTE = 8'h80;

  function automatic int unsigned bits_for(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/ca_row_engine_rule_row.sv
// Combinational next-generation of one CA row. Bit CELLS-1 is cell 0 (leftmost).
// CA_WRAP_EN selects a toroidal row instead of zero boundaries.
module ca_rule_row #(
  parameter int CELLS = 128
) (
  input  logic [CELLS-1:0] row,
  input  logic [7:0]       rule,
  output logic [CELLS-1:0] next
);

  // ext[j+2:j] is the {L,C,R} neighbourhood of row[j]
  logic [CELLS+1:0] ext;

`ifdef CA_WRAP_EN
  assign ext = {row[0], row, row[CELLS-1]};
`else
  assign ext = {1'b0, row, 1'b0};
`endif

  for (genvar j = 0; j < CELLS; j++) begin : g_cell
    assign next[j] = rule[ext[j+2:j]];
  end

endmodule

// File: rtl/ca_row_engine.sv
// Elementary CA generator writing successive generations as rows into RAM port A.
// Boundary mode selected by CA_WRAP_EN (see ca_rule_row).
module ca_row_engine
  import ca_row_engine_pkg::*;
#(
  parameter int ROW_BYTES = 16,
  parameter int ROWS      = 64,
  parameter int ADDR_W    = 10
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      init,
  input  logic                      step,
  input  logic [7:0]                rule,
  output logic                      busy,
  output logic                      done,
  output logic [$clog2(ROWS)-1:0]   cur_row,
  output logic [ADDR_W-1:0]         ram_addr,
  output logic [7:0]                ram_wdata,
  output logic                      ram_we,
  input  logic [7:0]                ram_rdata
);

  localparam int CELLS  = 8 * ROW_BYTES;
  localparam int ROW_W  = $clog2(ROWS);
  localparam int TOTAL  = ROWS * ROW_BYTES;
  localparam int CNT_W  = ADDR_W + 1;
  localparam int BYTE_W = bits_for(ROW_BYTES);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  ca_state_e        state;
  logic [CNT_W-1:0] cnt, cnt_inc;
  logic [7:0]       rule_q;
  logic [CELLS-1:0] row_buf, next_row;
  logic [ROW_W-1:0] nxt_idx;
  logic [ADDR_W-1:0] src_base, dst_base;
  logic [7:0]       next_bytes [ROW_BYTES];

  assign cnt_inc  = cnt + CNT_ONE;
  assign nxt_idx  = (cur_row == ROW_W'(ROWS-1)) ? '0 : cur_row + ROW_W'(1);
  assign src_base = ADDR_W'(cur_row) * ADDR_W'(ROW_BYTES);
  assign dst_base = ADDR_W'(nxt_idx) * ADDR_W'(ROW_BYTES);

  ca_rule_row #(.CELLS(CELLS)) u_rule (
    .row  (row_buf),
    .rule (rule_q),
    .next (next_row)
  );

  for (genvar b = 0; b < ROW_BYTES; b++) begin : g_byte
    assign next_bytes[b] = next_row[CELLS-1-8*b -: 8];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      cur_row   <= '0;
      ram_addr  <= '0;
      ram_wdata <= '0;
      ram_we    <= 1'b0;
      cnt       <= '0;
      rule_q    <= '0;
      row_buf   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (init) begin
            state     <= S_CLEAR;
            busy      <= 1'b1;
            cnt       <= '0;
            ram_addr  <= '0;
            ram_wdata <= (ROW_BYTES/2 == 0) ? SEED_BYTE : 8'h00;
            ram_we    <= 1'b1;
          end else if (step) begin
            state    <= S_LOAD;
            busy     <= 1'b1;
            cnt      <= '0;
            rule_q   <= rule;
            ram_addr <= src_base;
            ram_we   <= 1'b0;
          end
        end
        S_CLEAR: begin
          if (cnt == CNT_W'(TOTAL-1)) begin
            state     <= S_IDLE;
            busy      <= 1'b0;
            done      <= 1'b1;
            ram_we    <= 1'b0;
            ram_wdata <= '0;
            ram_addr  <= '0;
            cur_row   <= '0;
          end else begin
            cnt       <= cnt_inc;
            ram_addr  <= ADDR_W'(cnt_inc);
            ram_wdata <= (cnt_inc == CNT_W'(ROW_BYTES/2)) ? SEED_BYTE : 8'h00;
          end
        end
        S_LOAD: begin
          // read data trails its address by one cycle, so capture lags cnt by one
          if (cnt != '0) row_buf <= {row_buf[CELLS-9:0], ram_rdata};
          if (cnt == CNT_W'(ROW_BYTES)) begin
            state <= S_STORE;
            cnt   <= '0;
          end else begin
            cnt <= cnt_inc;
            if (cnt_inc < CNT_W'(ROW_BYTES)) ram_addr <= src_base + ADDR_W'(cnt_inc);
          end
        end
        S_STORE: begin
          if (cnt == CNT_W'(ROW_BYTES)) begin
            state   <= S_IDLE;
            busy    <= 1'b0;
            done    <= 1'b1;
            ram_we  <= 1'b0;
            cur_row <= nxt_idx;
          end else begin
            cnt       <= cnt_inc;
            ram_addr  <= dst_base + ADDR_W'(cnt);
            ram_wdata <= next_bytes[cnt[BYTE_W-1:0]];
            ram_we    <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ca_row_engine.sv
// Scoreboard bench for ca_row_engine: behavioural CA model predicts every RAM write.
module tb_ca_row_engine;
  localparam int N      = 16;
  localparam int ROWS   = 64;
  localparam int ADDR_W = 10;
  localparam int CELLS  = 8 * N;
  localparam int TOTAL  = N * ROWS;
  localparam int STEP_LAT = 2 * N + 3;   // posedges counted from the accepting edge (inclusive)
  localparam int INIT_LAT = TOTAL + 1;

  logic clk = 1'b0, reset_n = 1'b0, init = 1'b0, step = 1'b0;
  logic [7:0] rule = '0;
  logic busy, done, ram_we;
  logic [5:0] cur_row;
  logic [ADDR_W-1:0] ram_addr;
  logic [7:0] ram_wdata, ram_rdata;

  logic poke_en = 1'b0;
  logic [ADDR_W-1:0] poke_addr = '0;
  logic [7:0] poke_data = '0;
  logic [7:0] mem [TOTAL];

  typedef struct { int addr; int data; } wr_t;
  wr_t exp_q[$];
  wr_t mon_e;
  int checks = 0, failures = 0, done_cnt = 0;
  bit model [ROWS][CELLS];
  int mrow = 0;

  always #10 clk = ~clk;

  ca_row_engine #(.ROW_BYTES(N), .ROWS(ROWS), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset_n(reset_n), .init(init), .step(step), .rule(rule),
    .busy(busy), .done(done), .cur_row(cur_row),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we), .ram_rdata(ram_rdata)
  );

  always @(posedge clk) begin
    if (poke_en) mem[poke_addr] <= poke_data;
    else if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (reset_n) begin
      if (ram_we) begin
        if (exp_q.size() == 0) chk("unexpected_write_addr", int'(ram_addr), -1);
        else begin
          mon_e = exp_q.pop_front();
          chk("wr_addr", int'(ram_addr), mon_e.addr);
          chk("wr_data", int'(ram_wdata), mon_e.data);
        end
      end
      if (done) done_cnt++;
    end
  end

  task automatic push_clear();
    for (int a = 0; a < TOTAL; a++) exp_q.push_back('{a, (a == N/2) ? 8'h80 : 0});
    for (int r = 0; r < ROWS; r++) for (int i = 0; i < CELLS; i++) model[r][i] = 1'b0;
    model[0][4*N] = 1'b1;
    mrow = 0;
  endtask

  task automatic push_step(input logic [7:0] r);
    int dst, l, c, rr, v;
    bit nxt [CELLS];
    dst = (mrow + 1) % ROWS;
    for (int i = 0; i < CELLS; i++) begin
      c = model[mrow][i];
`ifdef CA_WRAP_EN
      l  = model[mrow][(i + CELLS - 1) % CELLS];
      rr = model[mrow][(i + 1) % CELLS];
`else
      l = 0; rr = 0;
      if (i > 0) l = model[mrow][i-1];
      if (i < CELLS-1) rr = model[mrow][i+1];
`endif
      nxt[i] = r[4*l + 2*c + rr];
    end
    for (int i = 0; i < CELLS; i++) model[dst][i] = nxt[i];
    for (int b = 0; b < N; b++) begin
      v = 0;
      for (int k = 0; k < 8; k++) v = v * 2 + int'(nxt[8*b + k]);
      exp_q.push_back('{dst * N + b, v});
    end
    mrow = dst;
  endtask

  // Issue one operation from a negedge; optionally toggle init/step while busy.
  task automatic run_op(input bit i_v, input bit s_v, input logic [7:0] r,
                        input int exp_lat, input bit noise);
    int d0, lat;
    bit got;
    d0 = done_cnt; got = 1'b0; lat = 0;
    init = i_v; step = s_v; rule = r;
    for (int n = 1; n <= 3000 && !got; n++) begin
      @(posedge clk); @(negedge clk);
      if (n == 1) begin
        init = 1'b0; step = 1'b0; rule = 8'($urandom);
      end else if (noise && n < exp_lat - 2) begin
        step = 1'($urandom_range(0, 1));
        init = 1'($urandom_range(0, 1));
      end else begin
        step = 1'b0; init = 1'b0;
      end
      if (done) begin got = 1'b1; lat = n; end
    end
    if (!got) chk("done_timeout", 0, 1);
    chk("latency", lat, exp_lat);
    chk("cur_row", int'(cur_row), mrow);
    chk("pending_writes", exp_q.size(), 0);
    chk("busy_after_done", int'(busy), 0);
    repeat (3) @(negedge clk);
    chk("done_pulses", done_cnt - d0, 1);
  endtask

  task automatic do_step(input logic [7:0] r, input bit noise);
    push_step(r);
    run_op(1'b0, 1'b1, r, STEP_LAT, noise);
  endtask

  task automatic poke_seed_cell0();
    for (int b = 0; b < N; b++) begin
      poke_en = 1'b1; poke_addr = ADDR_W'(mrow * N + b); poke_data = (b == 0) ? 8'h80 : 8'h00;
      @(posedge clk); @(negedge clk);
    end
    poke_en = 1'b0;
    for (int i = 0; i < CELLS; i++) model[mrow][i] = (i == 0);
  endtask

  initial begin
    int dst;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_we", int'(ram_we), 0);
    chk("rst_addr", int'(ram_addr), 0);
    chk("rst_wdata", int'(ram_wdata), 0);
    chk("rst_cur_row", int'(cur_row), 0);
    reset_n = 1'b1;
    @(negedge clk);

    push_clear();
    run_op(1'b1, 1'b0, 8'h00, INIT_LAT, 1'b0);

    do_step(8'd90, 1'b0);
    chk("r90_byte7", int'(mem[N+7]), 8'h01);
    chk("r90_byte8", int'(mem[N+8]), 8'h40);

    poke_seed_cell0();
    dst = (mrow + 1) % ROWS;
    do_step(8'hAA, 1'b0);
`ifdef CA_WRAP_EN
    chk("edge_byte15", int'(mem[dst*N+15]), 8'h01);
`else
    chk("edge_byte15", int'(mem[dst*N+15]), 8'h00);
`endif
    chk("edge_byte0", int'(mem[dst*N]), 8'h00);

    for (int s = 0; s < 6; s++) do_step(8'($urandom), 1'b1);

    push_clear();
    run_op(1'b1, 1'b0, 8'h00, INIT_LAT, 1'b0);
    for (int s = 0; s < ROWS; s++) do_step(8'hAA, 1'b0);
    chk("wrap_cur_row", int'(cur_row), 0);

    // init wins over step; noise during busy must be ignored
    push_clear();
    run_op(1'b1, 1'b1, 8'd30, INIT_LAT, 1'b1);

    do_step(8'd30, 1'b0);
    push_step(8'd110);
    step = 1'b1; rule = 8'd110;
    @(posedge clk); @(negedge clk);
    step = 1'b0;
    repeat (N + 8) @(negedge clk);
    chk("mid_store_we", int'(ram_we), 1);
    #3 reset_n = 1'b0;
    #1;
    chk("abort_busy", int'(busy), 0);
    chk("abort_done", int'(done), 0);
    chk("abort_we", int'(ram_we), 0);
    chk("abort_cur_row", int'(cur_row), 0);
    exp_q.delete();
    mrow = 0;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    do_step(8'($urandom), 1'b0);
    do_step(8'($urandom), 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
